axis_master_pkt: RTL

Parametrised AXI-Stream master that buffers producer words in an internal FIFO and emits them as length-programmable packets with `tlast` on the final beat and a completion pulse. It succeeds the single-word AXI master agent DUT. It sits between a local data producer and any AXI-Stream slave, decoupling producer rate from slave backpressure. All stream outputs are registered.

---
 rtl/axis_m_pkg.sv | 13 +
 rtl/axis_m_fifo.sv | 58 +++++
 rtl/axis_master_pkt.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/axis_m_pkg.sv
// Shared types and default parameters for the axis_master_pkt packet master.
package axis_m_pkg;

    typedef enum logic [0:0] {
        AXIS_M_IDLE = 1'b0,
        AXIS_M_SEND = 1'b1
    } axis_m_state_e;

    localparam int AXIS_M_DATA_WIDTH  = 32;
    localparam int AXIS_M_FIFO_DEPTH  = 8;
    localparam int AXIS_M_MAX_PKT_LEN = 16;

endpackage

// File: rtl/axis_m_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit
// so equal indices can be told apart as full or empty.
module axis_m_fifo
    import axis_m_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_M_DATA_WIDTH,
    parameter int FIFO_DEPTH = AXIS_M_FIFO_DEPTH,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty
);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  do_push, do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/axis_master_pkt.sv
// AXI-Stream packet master: FIFO-buffered producer words sent as length-programmed packets.
// Define AXIS_M_ASSERT_EN to compile in SVA protocol checks.
module axis_master_pkt
    import axis_m_pkg::*;
#(
    parameter int DATA_WIDTH  = AXIS_M_DATA_WIDTH,
    parameter int FIFO_DEPTH  = AXIS_M_FIFO_DEPTH,
    parameter int MAX_PKT_LEN = AXIS_M_MAX_PKT_LEN,
    parameter int LEN_WIDTH   = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        send_in,
    output logic                        full_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
    input  logic [LEN_WIDTH-1:0]        pkt_len_in,
    input  logic                        start_in,
    output logic                        busy_out,
    input  logic                        tready_in,
    output logic                        tvalid_out,
    output logic [DATA_WIDTH-1:0]       tdata_out,
    output logic                        tlast_out,
    output logic                        finish_out
);

    axis_m_state_e         state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  loaded_cnt_q, loaded_cnt_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  finish_q, finish_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  handshake, len_ok;

    assign fifo_push = send_in && !fifo_full;
    assign handshake = tvalid_q && tready_in;
    assign len_ok    = (pkt_len_in != '0) && (pkt_len_in <= LEN_WIDTH'(MAX_PKT_LEN));
    // A load pops the FIFO straight into the output register.
    assign fifo_pop  = (state_q == AXIS_M_SEND) && (loaded_cnt_q < len_q) &&
                       !fifo_empty && (!tvalid_q || tready_in);

    axis_m_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (fifo_push),
        .wdata  (data_in),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .count  (fifo_count_out),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        loaded_cnt_d = loaded_cnt_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        finish_d     = handshake && tlast_q;

        case (state_q)
            AXIS_M_IDLE: begin
                if (start_in && len_ok) begin
                    state_d      = AXIS_M_SEND;
                    len_d        = pkt_len_in;
                    loaded_cnt_d = '0;
                end
            end
            AXIS_M_SEND: begin
                if (handshake && tlast_q) state_d = AXIS_M_IDLE;
            end
        endcase

        if (fifo_pop) begin
            tvalid_d     = 1'b1;
            tdata_d      = fifo_rdata;
            tlast_d      = (loaded_cnt_q == len_q - LEN_WIDTH'(1));
            loaded_cnt_d = loaded_cnt_q + LEN_WIDTH'(1);
        end else if (handshake) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= AXIS_M_IDLE;
            len_q        <= '0;
            loaded_cnt_q <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            loaded_cnt_q <= loaded_cnt_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            finish_q     <= finish_d;
        end
    end

    assign full_out   = fifo_full;
    assign busy_out   = (state_q == AXIS_M_SEND);
    assign tvalid_out = tvalid_q;
    assign tdata_out  = tdata_q;
    assign tlast_out  = tlast_q;
    assign finish_out = finish_q;

`ifdef AXIS_M_ASSERT_EN
    logic [LEN_WIDTH-1:0] sva_beats_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)         sva_beats_q <= '0;
        else if (handshake) sva_beats_q <= tlast_q ? '0 : sva_beats_q + LEN_WIDTH'(1);
    end

    a_tvalid_hold: assert property (@(posedge aclk) disable iff (areset)
        tvalid_q && !tready_in |=> tvalid_q);
    a_payload_stable: assert property (@(posedge aclk) disable iff (areset)
        tvalid_q && !tready_in |=> $stable(tdata_q) && $stable(tlast_q));
    a_no_push_full: assert property (@(posedge aclk) disable iff (areset)
        fifo_full |-> !fifo_push);
    a_finish_pulse: assert property (@(posedge aclk) disable iff (areset)
        finish_q |=> !finish_q);
    a_beat_count: assert property (@(posedge aclk) disable iff (areset)
        handshake && tlast_q |-> (sva_beats_q + LEN_WIDTH'(1)) == len_q);
    // Async reset has already cleared every output by the first edge that sees it.
    a_reset_outputs: assert property (@(posedge aclk)
        areset |-> !tvalid_out && !tlast_out && !finish_out && !busy_out &&
                   !full_out && tdata_out == '0 && fifo_count_out == '0);
`else
    // Protocol checks compiled out; datapath behaviour is unchanged.
`endif

endmodule
